// File: rtl/cache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped cache controller.
package cache_pkg;

    localparam int ADDR_W      = 10;
    localparam int DATA_W      = 32;
    localparam int NUM_LINES   = 4;
    localparam int BLOCK_WORDS = 4;

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
        return addr[2+OFF_W +: IDX_W];
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] addr);
        return addr[2 +: OFF_W];
    endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/dirty/data storage: one combinational read port, one word write port,
// and a line-metadata update port. Only valid/dirty are reset.
module cache_line_store
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_word,
    input  logic              wr_en,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              meta_en,
    input  logic [TAG_W-1:0]  meta_tag,
    input  logic              meta_valid,
    input  logic              meta_dirty
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES][BLOCK_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

    // Line status bits; writes and metadata always target the line being read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (meta_en) begin
            valid_q[rd_idx] <= meta_valid;
            dirty_q[rd_idx] <= meta_dirty;
        end
    end

    // Tag and data arrays carry no reset; valid gates their use.
    always_ff @(posedge clk) begin
        if (meta_en) begin
            tag_q[rd_idx] <= meta_tag;
        end
        if (wr_en) begin
            data_q[rd_idx][wr_off] <= wr_data;
        end
    end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with word-serial memory port.
// Optional feature macro: CACHE_STATS_EN (saturating hit/miss counters).
module dm_cache_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              hit,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
);

    state_t            state, state_next;
    logic [OFF_W-1:0]  cnt, cnt_next;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              unused_addr_bits;

    logic [OFF_W-1:0]  rd_off;
    logic              rd_valid, rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [DATA_W-1:0] rd_word;
    logic              wr_en;
    logic [OFF_W-1:0]  wr_off;
    logic [DATA_W-1:0] wr_data;
    logic              meta_en, meta_valid, meta_dirty;
    logic              last_word;

    assign req_tag          = addr_tag(cpu_addr);
    assign req_idx          = addr_idx(cpu_addr);
    assign req_off          = addr_off(cpu_addr);
    assign unused_addr_bits = ^cpu_addr[1:0];

    // The single read port follows the CPU offset while comparing, the word counter otherwise.
    assign rd_off    = (state == COMPARE) ? req_off : cnt;
    assign hit       = (state == COMPARE) && rd_valid && (rd_tag == req_tag);
    assign cpu_rdata = (hit && !cpu_rw) ? rd_word : '0;
    assign last_word = (cnt == OFF_W'(BLOCK_WORDS - 1));

    cache_line_store u_store (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (req_idx),
        .rd_off     (rd_off),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_word    (rd_word),
        .wr_en      (wr_en),
        .wr_off     (wr_off),
        .wr_data    (wr_data),
        .meta_en    (meta_en),
        .meta_tag   (req_tag),
        .meta_valid (meta_valid),
        .meta_dirty (meta_dirty)
    );

    // State and word counter registers; reset abandons any block in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COMPARE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state, memory handshake and store update decode.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mem_req    = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wr_en      = 1'b0;
        wr_off     = req_off;
        wr_data    = cpu_wdata;
        meta_en    = 1'b0;
        meta_valid = 1'b1;
        meta_dirty = 1'b0;
        case (state)
            COMPARE: begin
                if (hit) begin
                    if (cpu_rw) begin
                        wr_en      = 1'b1;
                        meta_en    = 1'b1;
                        meta_dirty = 1'b1;
                    end
                end else begin
                    state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {rd_tag, req_idx, cnt, 2'b00};
                mem_wdata = rd_word;
                if (mem_done) begin
                    cnt_next = cnt + 1'b1;
                    if (last_word) begin
                        state_next = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, cnt, 2'b00};
                if (mem_done) begin
                    wr_en    = 1'b1;
                    wr_off   = cnt;
                    wr_data  = mem_rdata;
                    cnt_next = cnt + 1'b1;
                    if (last_word) begin
                        meta_en    = 1'b1;
                        state_next = COMPARE;
                    end
                end
            end
            default: begin
                state_next = COMPARE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    // Saturating statistics: a hit edge, or a miss edge leaving COMPARE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (state == COMPARE && !hit && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench: behavioural cache model feeds a memory-transfer scoreboard and a
// CPU-response scoreboard; a bench memory with programmable done delay serves the DUT.
module tb_dm_cache_ctrl;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_rw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              hit;
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic [15:0]       hit_count;
    logic [15:0]       miss_count;

    always #5 clk = ~clk;

    dm_cache_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .hit        (hit),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_done   (mem_done),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    typedef struct {
        logic              rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_xfer_t;

    typedef struct {
        logic              rw;
        logic [DATA_W-1:0] rdata;
        int                cycles;
    } cpu_resp_t;

    mem_xfer_t mem_q[$];
    cpu_resp_t resp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Bench memory
    logic [DATA_W-1:0] mem [256];
    int                mem_delay = 1;
    int                wait_cnt  = 0;
    bit                prev_pending = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic              prev_rw;

    // Serve one word per request after mem_delay cycles and score each completed transfer.
    always @(negedge clk) begin
        mem_xfer_t x;
        if (mem_req === 1'b1) begin
            if (prev_pending) begin
                check_eq("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
                check_eq("mem_rw_stable", 32'(mem_rw), 32'(prev_rw));
                if (mem_rw) check_eq("mem_wdata_stable", mem_wdata, prev_wdata);
            end
            if (wait_cnt >= mem_delay - 1) begin
                wait_cnt     = 0;
                prev_pending = 0;
                mem_done     = 1'b1;
                check_eq("mem_xfer_expected", 32'(mem_q.size() != 0), 32'd1);
                if (mem_q.size() != 0) begin
                    x = mem_q.pop_front();
                    check_eq("mem_addr", 32'(mem_addr), 32'(x.addr));
                    check_eq("mem_rw", 32'(mem_rw), 32'(x.rw));
                    if (x.rw) check_eq("mem_wdata", mem_wdata, x.data);
                end
                if (mem_rw) begin
                    mem[mem_addr[9:2]] = mem_wdata;
                    mem_rdata = '0;
                end else begin
                    mem_rdata = mem[mem_addr[9:2]];
                end
            end else begin
                wait_cnt++;
                mem_done     = 1'b0;
                mem_rdata    = '0;
                prev_pending = 1;
                prev_addr    = mem_addr;
                prev_wdata   = mem_wdata;
                prev_rw      = mem_rw;
            end
        end else begin
            mem_done     = 1'b0;
            mem_rdata    = '0;
            wait_cnt     = 0;
            prev_pending = 0;
        end
    end

    // Reference cache model
    logic              m_valid [NUM_LINES];
    logic              m_dirty [NUM_LINES];
    logic [TAG_W-1:0]  m_tag   [NUM_LINES];
    logic [DATA_W-1:0] m_data  [NUM_LINES][BLOCK_WORDS];
    int                exp_hits   = 0;
    int                exp_misses = 0;
    logic [DATA_W-1:0] last_rdata;

    task automatic model_reset();
        for (int i = 0; i < NUM_LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    task automatic model_access(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        logic [1:0] idx, off;
        logic [3:0] tg;
        int         words;
        idx   = a[5:4];
        off   = a[3:2];
        tg    = a[9:6];
        words = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            exp_misses++;
            if (m_valid[idx] && m_dirty[idx]) begin
                for (int w = 0; w < BLOCK_WORDS; w++) begin
                    mem_q.push_back('{1'b1, {m_tag[idx], idx, 2'(w), 2'b00}, m_data[idx][w]});
                end
                words += BLOCK_WORDS;
            end
            for (int w = 0; w < BLOCK_WORDS; w++) begin
                mem_q.push_back('{1'b0, {tg, idx, 2'(w), 2'b00}, 32'h0});
                m_data[idx][w] = mem[{tg, idx, 2'(w)}];
            end
            words += BLOCK_WORDS;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tg;
        end
        exp_hits++;
        if (rw) begin
            m_data[idx][off] = wd;
            m_dirty[idx]     = 1'b1;
        end
        resp_q.push_back('{rw, m_data[idx][off], (words == 0) ? 1 : 2 + words * mem_delay});
    endtask

    function automatic logic [15:0] stat_exp(input int v);
`ifdef CACHE_STATS_EN
        return 16'(v);
`else
        return (v < 0) ? 16'd1 : 16'd0;
`endif
    endfunction

    // Present one request (called just after a rising edge) and hold it until hit.
    task automatic cpu_access(input logic rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        cpu_resp_t r;
        int        cycles;
        bit        got;
        model_access(rw, a, wd);
        cpu_rw    = rw;
        cpu_addr  = a;
        cpu_wdata = wd;
        cycles    = 0;
        got       = 0;
        while (!got && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (hit === 1'b1) got = 1;
        end
        check_eq("hit_seen", 32'(got), 32'd1);
        if (got) begin
            r = resp_q.pop_front();
            check_eq("latency", 32'(cycles), 32'(r.cycles));
            if (!r.rw) check_eq("cpu_rdata", cpu_rdata, r.rdata);
            check_eq("mem_req_on_hit", 32'(mem_req), 32'd0);
            last_rdata = cpu_rdata;
        end
        @(posedge clk);
        #1;
        check_eq("hit_count", 32'(hit_count), 32'(stat_exp(exp_hits)));
        check_eq("miss_count", 32'(miss_count), 32'(stat_exp(exp_misses)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'(i * 32'h11);
        model_reset();
        mem_done  = 1'b0;
        mem_rdata = '0;
        reset     = 1'b1;
        cpu_rw    = 1'b0;
        cpu_addr  = 10'h014;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_hit", 32'(hit), 32'd0);
        check_eq("rst_mem_req", 32'(mem_req), 32'd0);
        check_eq("rst_mem_rw", 32'(mem_rw), 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_cpu_rdata", cpu_rdata, 32'd0);
        check_eq("rst_hit_count", 32'(hit_count), 32'd0);
        check_eq("rst_miss_count", 32'(miss_count), 32'd0);
        reset = 1'b0;

        cpu_access(1'b0, 10'h014, 32'h0);
        check_eq("rd_014", last_rdata, 32'h55);
        cpu_access(1'b0, 10'h054, 32'h0);
        check_eq("rd_054", last_rdata, 32'h165);
        cpu_access(1'b1, 10'h06C, 32'h114514);
        cpu_access(1'b1, 10'h02C, 32'h1919);
        check_eq("mem27_writeback", mem[27], 32'h114514);
        cpu_access(1'b0, 10'h02C, 32'h0);
        check_eq("rd_02c", last_rdata, 32'h1919);

        mem_delay = 3;
        cpu_access(1'b0, 10'h0A8, 32'h0);
        check_eq("mem11_writeback", mem[11], 32'h1919);
        check_eq("rd_0a8", last_rdata, 32'(42 * 32'h11));

        mem_delay = 1;
        model_access(1'b0, 10'h094, 32'h0);
        cpu_rw   = 1'b0;
        cpu_addr = 10'h094;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        check_eq("alloc_in_progress", 32'(mem_req), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mem_req_reset", 32'(mem_req), 32'd0);
        check_eq("hit_reset", 32'(hit), 32'd0);
        mem_q.delete();
        resp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_access(1'b0, 10'h094, 32'h0);
        check_eq("rd_094", last_rdata, 32'(37 * 32'h11));

        for (int k = 0; k < 20; k++) begin
            mem_delay = int'($urandom_range(1, 3));
            cpu_access(1'($urandom_range(0, 1)),
                       {2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00},
                       $urandom);
        end

        check_eq("mem_q_drained", 32'(mem_q.size()), 32'd0);
        check_eq("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
